shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//  Shares one DATA_W-bit holding register among NUM_REQ write requesters.
//  Round-robin arbitration with optional locked bursts.
//  Sits between several producer blocks and the 8-bit data register in the
//  sequential-circuit library; it sequences which producer's byte is captured.
//  Requester handshake: req/gnt valid-ready style; transfer = req[i] & gnt[i].
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    8   width of shared register and each wdata lane
//  MAX_HOLD  4   max consecutive transfers by one locked owner (1..15)
// PORTS
//  clk       in   1                  clock, rising edge
//  rst       in   1                  synchronous reset, active-low
//  req       in   NUM_REQ            request per requester; wdata valid while high
//  lock      in   NUM_REQ            sampled at transfer; asks to keep ownership
//  wdata     in   NUM_REQ*DATA_W     lane i = wdata[i*DATA_W +: DATA_W]
//  gnt       out  NUM_REQ            one-hot or zero; combinational from req/state
//  q         out  DATA_W             shared register contents
//  q_src     out  $clog2(NUM_REQ)    index of requester that last wrote q
//  q_upd     out  1                  1-cycle pulse in cycle after a write
//  locked    out  1                  high while state is LOCK
// BEHAVIOUR
//  Reset (rst==0 at edge): q=0, q_src=0, q_upd=0, ptr=0, owner=0, hold_cnt=0,
//   state=ARB. gnt forced to 0 whenever rst==0 (no transfer during reset).
//  States: ARB, LOCK.
//  ARB: gnt = first set req bit searching ptr, ptr+1, ... mod NUM_REQ.
//  LOCK: if req[owner]==1, gnt = only owner. If req[owner]==0, lock is
//   released and the same cycle arbitrates as ARB (no bubble).
//   In that case, ptr = owner+1.
//  On transfer from i at edge:
//   q<=lane i, q_src<=i, q_upd<=1 (next cycle only).
//  Latency: req sampled cycle t -> q valid cycle t+1.
//  Transitions after a transfer from i:
//   lock[i]==1 and hold_cnt+1 < MAX_HOLD:
//    state=LOCK, owner=i, hold_cnt++.
//   otherwise:
//    state=ARB, ptr=(i+1) mod NUM_REQ, hold_cnt=0 (forced release at cap
//    even with lock high).
//   MAX_HOLD=1 disables locking.
//  No transfer in ARB: ptr unchanged.
//  Wrap-around: ptr from NUM_REQ-1 goes to 0.
//  Back-to-back: a requester holding req high in ARB with others idle
//   transfers every cycle.
//  Reset mid-burst: abandons LOCK immediately. The cycle after rst returns
//   high arbitrates from ptr=0.
//  No X: gnt is all-zero when req==0. q is held when there is no transfer.
// STRUCTURE
//  shared_reg_arbiter_pkg holds:
//   - state typedef {ARB, LOCK}
//   - localparam ID_W=$clog2(NUM_REQ)
//   - HOLD_W sizing for hold_cnt
//  Sub-module rr_arbiter (NUM_REQ): req + ptr -> one-hot gnt, combinational,
//   double-width mask/priority.
//  Top holds FSM, ptr/owner/hold_cnt, lane mux, and q/q_src/q_upd registers.
// TESTING
//  1. Reset: rst=0 for 3 cycles with req=4'b1111
//     -> gnt=0, q=0, q_src=0, q_upd=0, locked=0.
//  2. Round-robin: req=4'b1111, lock=0, lanes 8'hA0..A3 for 5 cycles
//     -> q_src sequence 0,1,2,3,0; q sequence A0,A1,A2,A3,A0.
//  3. Lock cap: req=4'b0011, lock[0]=1, MAX_HOLD=4
//     -> four transfers from 0 with locked=1 on the middle three,
//        then gnt=4'b0010.
//  4. Lock release: lock[0]=1, drop req[0] in cycle 2 while req[2]=1
//     -> same cycle gnt=4'b0100; q=lane2 next cycle; no bubble.
//  5. Reset mid-burst: rst=0 during LOCK owner=1
//     -> locked=0 next cycle; after release, req=4'b1010 grants 1 (ptr=0).
//  6. Idle/hold: req=0 for 10 cycles
//     -> q stable, q_upd=0, gnt=0; single req[3] -> q_src=3 after 1 cycle.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter: default sizing,
// FSM encoding and a wrap-around index helper.
package shared_reg_arbiter_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_HOLD_DEF = 4;

  localparam int ID_W   = $clog2(NUM_REQ_DEF);
  // Wide enough for any hold cap up to 15.
  localparam int HOLD_W = 4;

  typedef logic [0:0] state_t;
  localparam state_t ST_ARB  = 1'b0;
  localparam state_t ST_LOCK = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first set request at or after ptr,
// wrapping via a doubled request vector.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [2*NUM_REQ-1:0] dreq;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;
  logic [2*NUM_REQ-1:0] sel;

  always_comb begin
    dreq   = {req, req};
    mask   = {(2*NUM_REQ){1'b1}} << ptr;
    masked = dreq & mask;
    // Isolate the lowest set bit; the upper copy supplies the wrapped candidates.
    sel    = masked & (~masked + {{(2*NUM_REQ-1){1'b0}}, 1'b1});
    gnt    = sel[NUM_REQ-1:0] | sel[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shares one holding register among several requesters with round-robin
// arbitration and capped locked bursts.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic [$clog2(NUM_REQ)-1:0]  q_src,
  output logic                        q_upd,
  output logic                        locked
);

  localparam int SRC_W = $clog2(NUM_REQ);

  state_t              state_reg;
  logic [SRC_W-1:0]    ptr_reg;
  logic [SRC_W-1:0]    owner_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [DATA_W-1:0]   q_reg;
  logic [SRC_W-1:0]    q_src_reg;
  logic                q_upd_reg;

  logic [DATA_W-1:0]   lanes [NUM_REQ];
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [SRC_W-1:0]    arb_ptr;
  logic [SRC_W-1:0]    owner_next;
  logic [SRC_W-1:0]    gnt_idx;
  logic [SRC_W-1:0]    gnt_next;
  logic [HOLD_W:0]     hold_inc;
  logic                owner_req;
  logic                release_now;
  logic                keep_lock;
  logic                xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lanes[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign owner_oh    = NUM_REQ'(1) << owner_reg;
  assign owner_req   = |(req & owner_oh);
  assign release_now = (state_reg == ST_LOCK) && !owner_req;
  assign owner_next  = SRC_W'(wrap_inc(32'(owner_reg), 32'(NUM_REQ)));
  // An owner dropping req hands the cycle straight to the next requester.
  assign arb_ptr     = release_now ? owner_next : ptr_reg;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (SRC_W)
  ) u_rr (
    .req (req),
    .ptr (arb_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    gnt = '0;
    if (rst) begin
      if ((state_reg == ST_LOCK) && owner_req) gnt = owner_oh;
      else                                     gnt = rr_gnt;
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = SRC_W'(i);
    end
  end

  assign xfer      = |gnt;
  assign gnt_next  = SRC_W'(wrap_inc(32'(gnt_idx), 32'(NUM_REQ)));
  // A new owner after a release starts counting from zero.
  assign hold_inc  = {1'b0, (release_now ? {HOLD_W{1'b0}} : hold_reg)} + {{HOLD_W{1'b0}}, 1'b1};
  assign keep_lock = |(lock & gnt) && (hold_inc < (HOLD_W+1)'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_ARB;
      ptr_reg   <= '0;
      owner_reg <= '0;
      hold_reg  <= '0;
      q_reg     <= '0;
      q_src_reg <= '0;
      q_upd_reg <= 1'b0;
    end else begin
      q_upd_reg <= xfer;
      if (xfer) begin
        q_reg     <= lanes[gnt_idx];
        q_src_reg <= gnt_idx;
        if (keep_lock) begin
          state_reg <= ST_LOCK;
          owner_reg <= gnt_idx;
          hold_reg  <= hold_inc[HOLD_W-1:0];
        end else begin
          state_reg <= ST_ARB;
          ptr_reg   <= gnt_next;
          hold_reg  <= '0;
        end
      end else if (release_now) begin
        state_reg <= ST_ARB;
        ptr_reg   <= owner_next;
        hold_reg  <= '0;
      end
    end
  end

  assign q      = q_reg;
  assign q_src  = q_src_reg;
  assign q_upd  = q_upd_reg;
  assign locked = (state_reg == ST_LOCK);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Vector-table bench for shared_reg_arbiter: checks gnt/locked before each edge and
// q/q_src/q_upd after it against a scoreboard queue.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_src;
  logic        q_upd;
  logic        locked;

  shared_reg_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .MAX_HOLD (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lock   (lock),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .q_src  (q_src),
    .q_upd  (q_upd),
    .locked (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic        lkd;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [1:0] src;
    logic       upd;
  } exp_t;

  localparam logic [31:0] LA = 32'hA3A2A1A0;
  localparam logic [31:0] LB = 32'hB3B2B1B0;
  localparam logic [31:0] LC = 32'hC3C2C1C0;
  localparam logic [31:0] LD = 32'hD3D2D1D0;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_q   = 8'h00;
  logic [1:0] m_src = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int n);
    exp_t e;
    rst   = v.r;
    req   = v.req;
    lock  = v.lock;
    wdata = v.wd;
    #1;
    chk($sformatf("gnt#%0d", n), 32'(gnt), 32'(v.gnt));
    chk($sformatf("locked#%0d", n), 32'(locked), 32'(v.lkd));
    if (!v.r) begin
      m_q   = 8'h00;
      m_src = 2'd0;
      e.upd = 1'b0;
    end else if (v.gnt != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (v.gnt[i]) begin
          m_src = 2'(i);
          m_q   = v.wd[i*8 +: 8];
        end
      end
      e.upd = 1'b1;
    end else begin
      e.upd = 1'b0;
    end
    e.q   = m_q;
    e.src = m_src;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("q#%0d", n), 32'(q), 32'(e.q));
    chk($sformatf("q_src#%0d", n), 32'(q_src), 32'(e.src));
    chk($sformatf("q_upd#%0d", n), 32'(q_upd), 32'(e.upd));
    $display("txn %0d: rst=%b req=%b lock=%b gnt=%b locked=%b -> q=%h q_src=%0d q_upd=%b",
             n, v.r, v.req, v.lock, v.gnt, v.lkd, q, q_src, q_upd);
  endtask

  initial begin
    rst = 1'b0; req = '0; lock = '0; wdata = '0;

    // Reset with all requesters active
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 4'b1111, 4'b0000, LA, 4'b0000, 1'b0});
    // Round robin over all four lanes
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, LA, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, LA, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, LA, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, LA, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, LA, 4'b0001, 1'b0});
    // Single requester 3 moves ptr back to 0
    vecs.push_back('{1'b1, 4'b1000, 4'b0000, LA, 4'b1000, 1'b0});
    // Lock cap: four transfers from 0, then forced handoff to 1
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, LB, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, LB, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, LB, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, LB, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, LB, 4'b0010, 1'b0});
    // Lock release: owner 0 drops req, requester 2 served in the same cycle
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, LC, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0001, LC, 4'b0100, 1'b1});
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, LC, 4'b0100, 1'b0});
    // Reset in the middle of a burst owned by 1
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, LD, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, LD, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, LD, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b1010, 4'b0000, LD, 4'b0010, 1'b0});
    // Idle: q held, no grant
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 4'b0000, 4'b0000, LA, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 4'b0000, LB, 4'b1000, 1'b0});

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Back-to-back: lone requester 2 transfers every cycle with changing data
    step('{1'b1, 4'b0100, 4'b0000, 32'h00110000, 4'b0100, 1'b0}, 100);
    step('{1'b1, 4'b0100, 4'b0000, 32'h00220000, 4'b0100, 1'b0}, 101);
    step('{1'b1, 4'b0100, 4'b0000, 32'h00330000, 4'b0100, 1'b0}, 102);
    step('{1'b1, 4'b0000, 4'b0000, 32'h00440000, 4'b0000, 1'b0}, 103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
